// File: rtl/datamem_access_ctrl.sv
// Memory-stage access controller: runs one req/ack transaction per load/store,
// stalls the pipeline while it is outstanding, and aborts after TIMEOUT cycles.
module datamem_access_ctrl #(
  parameter int AW      = 64,
  parameter int DW      = 64,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ReadMem,
  input  logic          MemWr,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall,
  output logic [DW-1:0] rdata,
  output logic          rdata_valid,
  output logic          err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata
);

  localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state;
  logic [CW-1:0] waitCnt;
  logic          opValid;
  logic          aligned;

  assign opValid = ReadMem | MemWr;
  assign aligned = (addr[2:0] == 3'b000);
  assign stall   = ((state == IDLE) && opValid && aligned) || (state == ACCESS);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      waitCnt     <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      err         <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else begin
      rdata_valid <= 1'b0;
      err         <= 1'b0;
      case (state)
        IDLE: begin
          if (opValid) begin
            if (aligned) begin
              // MemWr wins when both requests are raised together
              state     <= ACCESS;
              mem_req   <= 1'b1;
              mem_we    <= MemWr;
              mem_addr  <= addr;
              mem_wdata <= wdata;
              waitCnt   <= '0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            state   <= DONE;
            mem_req <= 1'b0;
            if (!mem_we) begin
              rdata       <= mem_rdata;
              rdata_valid <= 1'b1;
            end
          end else if (waitCnt == CNT_LAST) begin
            // ack in the final cycle still completes; only a missing one aborts
            state   <= DONE;
            mem_req <= 1'b0;
            err     <= 1'b1;
            if (!mem_we) rdata <= '0;
          end else begin
            waitCnt <= waitCnt + CW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_datamem_access_ctrl.sv
// Randomized bench for datamem_access_ctrl: each transaction is expanded into its
// expected per-cycle waveform and compared against the DUT on every falling edge.
module tb_datamem_access_ctrl;
  localparam int AW = 64, DW = 64, TIMEOUT = 16;

  logic          clk = 1'b0, reset = 1'b0;
  logic          ReadMem = 1'b0, MemWr = 1'b0, mem_ack = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0, mem_rdata = '0;
  logic          stall, rdata_valid, err, mem_req, mem_we;
  logic [DW-1:0] rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  datamem_access_ctrl #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .ReadMem(ReadMem), .MemWr(MemWr), .addr(addr),
    .wdata(wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall),
    .rdata(rdata), .rdata_valid(rdata_valid), .err(err), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  typedef struct packed {
    logic          stall, mem_req, mem_we, rdata_valid, err;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, rdata;
  } obs_t;

  // model state: what the memory side should be holding, and the last load result
  logic [AW-1:0] mAddr = '0;
  logic [DW-1:0] mWdata = '0, mRdata = '0;
  logic          mWe = 1'b0;
  obs_t          exp;
  bit            expOn = 0;
  int            reqTotal = 0, stallTotal = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
    end
  endtask

  function automatic obs_t base();
    obs_t o;
    o = '0;
    o.mem_we = mWe; o.mem_addr = mAddr; o.mem_wdata = mWdata; o.rdata = mRdata;
    return o;
  endfunction

  always @(negedge clk) begin
    if (mem_req === 1'b1) reqTotal++;
    if (stall === 1'b1) stallTotal++;
    if (expOn) begin
      chk("stall", 64'(stall), 64'(exp.stall));
      chk("mem_req", 64'(mem_req), 64'(exp.mem_req));
      chk("rdata_valid", 64'(rdata_valid), 64'(exp.rdata_valid));
      chk("err", 64'(err), 64'(exp.err));
      chk("rdata", rdata, exp.rdata);
      chk("mem_we", 64'(mem_we), 64'(exp.mem_we));
      chk("mem_addr", mem_addr, exp.mem_addr);
      chk("mem_wdata", mem_wdata, exp.mem_wdata);
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle();
    cycle();
    ReadMem = 1'b0; MemWr = 1'b0;
    mem_ack = 1'($urandom_range(0, 1)); mem_rdata = {$urandom, $urandom};
    exp = base();
  endtask

  // waitN = ack after waitN wait cycles; waitN >= TIMEOUT means no ack at all
  task automatic runOp(input bit rd, input bit wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input int waitN, input logic [DW-1:0] rv);
    bit abort;
    int len;
    logic [2:0] lowBits;
    lowBits = a[2:0];
    cycle();
    ReadMem = rd; MemWr = wr; addr = a; wdata = wd;
    mem_ack = 1'($urandom_range(0, 1)); mem_rdata = {$urandom, $urandom};
    exp = base();
    exp.stall = (lowBits == 3'b000);
    if (lowBits != 3'b000) begin
      idleCycle();
      exp.err = 1'b1;
      return;
    end
    mAddr = a; mWdata = wd; mWe = wr;
    abort = (waitN >= TIMEOUT);
    len = abort ? TIMEOUT : waitN + 1;
    for (int i = 1; i <= len; i++) begin
      cycle();
      mem_ack = (!abort && i == len);
      mem_rdata = (i == len) ? rv : {$urandom, $urandom};
      exp = base();
      exp.stall = 1'b1; exp.mem_req = 1'b1;
    end
    if (!wr) mRdata = abort ? '0 : rv;
    cycle();  // DONE: op still presented, stray acks must not matter
    mem_ack = 1'($urandom_range(0, 1)); mem_rdata = {$urandom, $urandom};
    exp = base();
    exp.rdata_valid = !wr && !abort;
    exp.err = abort;
  endtask

  initial begin
    int r0, s0;
    logic [AW-1:0] ra;
    bit rd, wr;

    #2;
    chk("reset_stall", 64'(stall), 64'd0);
    chk("reset_mem_req", 64'(mem_req), 64'd0);
    chk("reset_rdata", rdata, 64'd0);
    chk("reset_err", 64'(err), 64'd0);
    chk("reset_mem_addr", mem_addr, 64'd0);
    cycle(); cycle();
    reset = 1'b1;
    exp = base(); expOn = 1;
    idleCycle();

    // directed load, zero wait states
    runOp(1, 0, 64'h40, 64'h0, 0, 64'hDEADBEEF);
    #1;
    chk("lit_load_rdata", rdata, 64'hDEADBEEF);
    chk("lit_load_valid", 64'(rdata_valid), 64'd1);
    chk("lit_load_we", 64'(mem_we), 64'd0);
    idleCycle();

    // directed store, three wait states
    r0 = reqTotal; s0 = stallTotal;
    runOp(0, 1, 64'h88, 64'h1234, 3, 64'h5555);
    idleCycle(); idleCycle();
    chk("lit_store_req_cycles", 64'(reqTotal - r0), 64'd4);
    chk("lit_store_stall_cycles", 64'(stallTotal - s0), 64'd5);
    chk("lit_store_rdata_kept", rdata, 64'hDEADBEEF);

    // misaligned load
    r0 = reqTotal; s0 = stallTotal;
    runOp(1, 0, 64'h43, 64'h0, 0, 64'h0);
    idleCycle();
    chk("lit_misaligned_req", 64'(reqTotal - r0), 64'd0);
    chk("lit_misaligned_stall", 64'(stallTotal - s0), 64'd0);

    // timeout
    r0 = reqTotal;
    runOp(1, 0, 64'h10, 64'h0, TIMEOUT + 5, 64'hFFFF);
    idleCycle();
    chk("lit_timeout_req_cycles", 64'(reqTotal - r0), 64'd16);
    chk("lit_timeout_rdata", rdata, 64'd0);

    // conflicting request is a store
    runOp(1, 1, 64'h200, 64'hABCD, 1, 64'h7777);
    chk("lit_conflict_we", 64'(mem_we), 64'd1);
    idleCycle();

    // ack at the very last ACCESS cycle completes instead of aborting
    runOp(1, 0, 64'h18, 64'h0, TIMEOUT - 1, 64'h1122334455667788);
    idleCycle();

    for (int n = 0; n < 150; n++) begin
      rd = 1'($urandom_range(0, 1));
      wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      ra = {$urandom, $urandom};
      if ($urandom_range(0, 4) != 0) ra[2:0] = 3'b000;
      runOp(rd, wr, ra, {$urandom, $urandom},
            ($urandom_range(0, 5) == 0) ? $urandom_range(TIMEOUT - 1, TIMEOUT + 2)
                                        : $urandom_range(0, 4),
            {$urandom, $urandom});
      for (int k = $urandom_range(0, 2); k > 0; k--) idleCycle();
    end

    // asynchronous reset in the middle of ACCESS
    runOp(1, 0, 64'h300, 64'h0, 1, 64'h99);
    cycle();
    ReadMem = 1'b1; addr = 64'h308; mem_ack = 1'b0;
    exp = base(); exp.stall = 1'b1;
    cycle();
    exp = base(); mAddr = 64'h308; mWe = 1'b0; mWdata = wdata;
    exp = base(); exp.stall = 1'b1; exp.mem_req = 1'b1;
    #2;
    expOn = 0;
    reset = 1'b0; ReadMem = 1'b0; mem_ack = 1'b1;
    #1;
    chk("async_reset_mem_req", 64'(mem_req), 64'd0);
    chk("async_reset_stall", 64'(stall), 64'd0);
    chk("async_reset_rdata", rdata, 64'd0);
    chk("async_reset_mem_addr", mem_addr, 64'd0);
    mAddr = '0; mWdata = '0; mRdata = '0; mWe = 1'b0;
    cycle();
    reset = 1'b1;
    exp = base(); expOn = 1;
    cycle();
    exp = base();  // ack still high after reset: must be ignored
    cycle();
    mem_ack = 1'b0;
    exp = base();
    runOp(1, 0, 64'h48, 64'h0, 2, 64'hCAFE);
    idleCycle();
    idleCycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
